// File: rtl/tm1638_serial_ctrl_if.sv
// Host-side byte handshake between display/key-scan logic and the TM1638 sequencer.
// The master issues bytes and the slave (sequencer) reports completion and read data.
interface tm1638_serial_ctrl_if;
    logic       start;
    logic       rw;
    logic       last;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;

    modport master (output start, rw, last, wdata, input busy, done, rdata);
    modport slave  (input start, rw, last, wdata, output busy, done, rdata);
endinterface

// File: rtl/tm1638_serial_ctrl.sv
// TM1638 three-wire byte sequencer: drives STB/CLK/DIO from a half-period tick timer,
// shifting bytes LSB first and sampling key-scan bits on the CLK rising edge.
module tm1638_serial_ctrl #(
    parameter int unsigned CLK_IN   = 100_000_000,
    parameter int unsigned BIT_RATE = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    tm1638_serial_ctrl_if.slave        host,
    output logic                       tm_stb,
    output logic                       tm_clk,
    output logic                       dio_out,
    output logic                       dio_oe,
    input  logic                       dio_in
);
    localparam int unsigned HALF = CLK_IN / BIT_RATE / 2;
    localparam int unsigned TW   = (HALF > 1) ? $clog2(2 * HALF) : 1;

    if (HALF < 1) begin : g_bad_half
        $error("tm1638_serial_ctrl: CLK_IN/BIT_RATE/2 must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_TURN, S_CLK_LO, S_CLK_HI, S_END, S_GAP, S_HOLD
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          rw_q;
    logic          last_q;

    logic [TW-1:0] phase_max_c;
    logic          phase_end_c;
    logic          accept_c;

    // TURN is the only phase lasting a full bit period; all others are one half-period.
    always_comb begin
        phase_max_c = TW'(HALF - 1);
        if (state == S_TURN) phase_max_c = TW'(2 * HALF - 1);
    end

    assign phase_end_c = (timer == phase_max_c);
    // A start coinciding with a visible done pulse belongs to the finishing byte and is dropped.
    assign accept_c    = host.start && !host.busy && !host.done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            rw_q       <= 1'b0;
            last_q     <= 1'b0;
            tm_stb     <= 1'b1;
            tm_clk     <= 1'b1;
            dio_out    <= 1'b0;
            dio_oe     <= 1'b0;
            host.busy  <= 1'b0;
            host.done  <= 1'b0;
            host.rdata <= '0;
        end else begin
            host.done <= 1'b0;

            if (state == S_IDLE || state == S_HOLD || phase_end_c) timer <= '0;
            else                                                    timer <= timer + TW'(1);

            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        rw_q      <= host.rw;
                        last_q    <= host.last;
                        shift     <= host.wdata;
                        host.busy <= 1'b1;
                        tm_stb    <= 1'b0;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (phase_end_c) begin
                        if (rw_q) begin
                            state <= S_TURN;
                        end else begin
                            state   <= S_CLK_LO;
                            tm_clk  <= 1'b0;
                            dio_oe  <= 1'b1;
                            dio_out <= shift[0];
                        end
                    end
                end
                S_TURN: begin
                    if (phase_end_c) begin
                        state  <= S_CLK_LO;
                        tm_clk <= 1'b0;
                    end
                end
                S_CLK_LO: begin
                    // Read bits are captured on the same edge that raises CLK.
                    if (phase_end_c) begin
                        state  <= S_CLK_HI;
                        tm_clk <= 1'b1;
                        if (rw_q) shift <= {dio_in, shift[7:1]};
                    end
                end
                S_CLK_HI: begin
                    if (phase_end_c) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state   <= S_END;
                            dio_oe  <= 1'b0;
                            dio_out <= 1'b0;
                        end else begin
                            state  <= S_CLK_LO;
                            tm_clk <= 1'b0;
                            if (!rw_q) begin
                                shift   <= {1'b0, shift[7:1]};
                                dio_out <= shift[1];
                            end
                        end
                    end
                end
                S_END: begin
                    if (phase_end_c) begin
                        if (last_q) begin
                            state  <= S_GAP;
                            tm_stb <= 1'b1;
                        end else begin
                            state     <= S_HOLD;
                            host.done <= 1'b1;
                            host.busy <= 1'b0;
                            if (rw_q) host.rdata <= shift;
                        end
                    end
                end
                S_GAP: begin
                    if (phase_end_c) begin
                        state     <= S_IDLE;
                        host.done <= 1'b1;
                        host.busy <= 1'b0;
                        if (rw_q) host.rdata <= shift;
                    end
                end
                S_HOLD: begin
                    // STB stays low between chained bytes, so SETUP is skipped.
                    if (accept_c) begin
                        rw_q      <= host.rw;
                        last_q    <= host.last;
                        shift     <= host.wdata;
                        host.busy <= 1'b1;
                        if (host.rw) begin
                            state <= S_TURN;
                        end else begin
                            state   <= S_CLK_LO;
                            tm_clk  <= 1'b0;
                            dio_oe  <= 1'b1;
                            dio_out <= host.wdata[0];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tm1638_serial_ctrl.sv
// Randomised scoreboard bench for tm1638_serial_ctrl: a driver queues expected bytes,
// a pin-level monitor acts as the TM1638 device and checks each byte at its done pulse.
module tb_tm1638_serial_ctrl;
    localparam int unsigned CLK_IN   = 8;
    localparam int unsigned BIT_RATE = 2;
    localparam int          H        = 2;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic dio_in = 1'b0;
    logic tm_stb, tm_clk, dio_out, dio_oe;

    tm1638_serial_ctrl_if host();

    tm1638_serial_ctrl #(.CLK_IN(CLK_IN), .BIT_RATE(BIT_RATE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .host    (host),
        .tm_stb  (tm_stb),
        .tm_clk  (tm_clk),
        .dio_out (dio_out),
        .dio_oe  (dio_oe),
        .dio_in  (dio_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rw;
        bit         last;
        logic [7:0] data;
        bit         from_idle;
        int         acc;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit from_idle = 1'b1;

    // Device-side state tracked by the monitor.
    int         nbits        = 0;
    int         first_fall   = -1;
    int         oe_cnt       = 0;
    int         clk_bad      = 0;
    int         low_len      = 0;
    int         stb_low_cnt  = 0;
    int         last_stb_low = 0;
    int         stb_rise_cyc = 0;
    int         inv_bad      = 0;
    logic [7:0] cap          = '0;
    logic [7:0] dev_byte     = '0;
    logic [7:0] exp_rdata    = '0;
    bit         prev_clk     = 1'b1;
    bit         prev_stb     = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic check_done();
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("bits_per_byte", nbits, 8);
            chk("clk_low_width_errs", clk_bad, 0);
            chk("busy_at_done", int'(host.busy), 0);
            chk("first_clk_latency", first_fall - e.acc,
                (e.from_idle ? H : 0) + (e.rw ? 2 * H : 0));
            if (e.rw) begin
                exp_rdata = e.data;
                chk("read_oe_cycles", oe_cnt, 0);
            end else begin
                chk("write_byte", int'(cap), int'(e.data));
                chk("write_oe_cycles", oe_cnt, 16 * H);
            end
            chk("rdata", int'(host.rdata), int'(exp_rdata));
            if (e.last) begin
                chk("done_after_stb_rise", cyc - stb_rise_cyc, H);
                chk("stb_high_at_done", int'(tm_stb), 1);
                if (e.from_idle)
                    chk("stb_low_len", last_stb_low, H + (e.rw ? 2 * H : 0) + 16 * H + H);
            end else begin
                chk("stb_low_at_done", int'(tm_stb), 0);
            end
        end
        nbits      = 0;
        first_fall = -1;
        oe_cnt     = 0;
        clk_bad    = 0;
        cap        = '0;
    endtask

    // Pin monitor and TM1638 device model: drives key bits while CLK is low, captures on rise.
    always @(negedge clk) begin
        if (!rst_n) begin
            nbits      = 0;
            first_fall = -1;
            oe_cnt     = 0;
            clk_bad    = 0;
            low_len    = 0;
            cap        = '0;
            exp_rdata  = '0;
            prev_clk   = 1'b1;
            prev_stb   = 1'b1;
        end else begin
            if (dio_oe && tm_stb) inv_bad++;
            if (dio_oe) oe_cnt++;
            if (prev_stb && !tm_stb) stb_low_cnt = 0;
            if (!tm_stb) stb_low_cnt++;
            if (!prev_stb && tm_stb) begin
                stb_rise_cyc = cyc;
                last_stb_low = stb_low_cnt;
            end
            if (prev_clk && !tm_clk) begin
                if (first_fall < 0) first_fall = cyc;
                low_len = 0;
                if (nbits < 8) dio_in = dev_byte[nbits[2:0]];
            end
            if (!tm_clk) low_len++;
            if (!prev_clk && tm_clk) begin
                if (low_len != H) clk_bad++;
                if (nbits < 8) cap[nbits[2:0]] = dio_out;
                nbits++;
            end
            if (host.done) check_done();
            prev_clk = tm_clk;
            prev_stb = tm_stb;
        end
    end

    task automatic issue(input bit r, input bit l, input logic [7:0] d);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while ((host.busy || host.done) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("issue_wait_timeout", int'(n >= 400), 0);
        if (r) dev_byte = d;
        host.rw    = r;
        host.last  = l;
        host.wdata = r ? 8'($urandom) : d;
        host.start = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        chk("busy_after_start", int'(host.busy), 1);
        e.rw        = r;
        e.last      = l;
        e.data      = d;
        e.from_idle = from_idle;
        e.acc       = cyc;
        sb.push_back(e);
        from_idle = l;
    endtask

    // Pulses start with garbage whenever the DUT must ignore it.
    task automatic junk(input int n);
        repeat (n) begin
            @(negedge clk);
            if (host.busy || host.done) begin
                host.start = 1'b1;
                host.rw    = 1'($urandom);
                host.last  = 1'($urandom);
                host.wdata = 8'($urandom);
                @(negedge clk);
                host.start = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        host.start = 1'b0;
        host.rw    = 1'b0;
        host.last  = 1'b0;
        host.wdata = '0;

        // Reset values while start toggles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            host.start = ~host.start;
            chk("rst_stb", int'(tm_stb), 1);
            chk("rst_clk", int'(tm_clk), 1);
            chk("rst_oe", int'(dio_oe), 0);
            chk("rst_busy", int'(host.busy), 0);
            chk("rst_done", int'(host.done), 0);
            chk("rst_rdata", int'(host.rdata), 0);
        end
        host.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_stb", int'(tm_stb), 1);
        chk("idle_busy", int'(host.busy), 0);
        chk("idle_oe", int'(dio_oe), 0);

        // Single write, chained write, command + read.
        issue(1'b0, 1'b1, 8'h8F);
        issue(1'b0, 1'b0, 8'h40);
        issue(1'b0, 1'b1, 8'hC0);
        issue(1'b0, 1'b0, 8'h42);
        issue(1'b1, 1'b1, 8'hA5);

        // Busy collision across a whole byte including its done cycle.
        issue(1'b0, 1'b1, 8'h5A);
        junk(60);

        // Reset during bit 4 of a write.
        issue(1'b0, 1'b1, 8'hF0);
        begin
            int n = 0;
            while (nbits < 4 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("midop_wait_timeout", int'(n >= 200), 0);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_stb", int'(tm_stb), 1);
        chk("midrst_clk", int'(tm_clk), 1);
        chk("midrst_oe", int'(dio_oe), 0);
        chk("midrst_busy", int'(host.busy), 0);
        chk("midrst_done", int'(host.done), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        from_idle = 1'b1;
        repeat (20) @(negedge clk);
        issue(1'b0, 1'b1, 8'h3C);

        // Randomised frames with collisions and idle gaps.
        for (int i = 0; i < 40; i++) begin
            bit r = 1'($urandom);
            bit l = (i == 39) ? 1'b1 : 1'($urandom);
            logic [7:0] d = 8'($urandom);
            junk(int'($urandom_range(0, 30)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(r, l, d);
        end

        begin
            int n = 0;
            while (sb.size() != 0 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            chk("drain_timeout", sb.size(), 0);
        end
        repeat (10) @(negedge clk);
        chk("oe_while_stb_high", inv_bad, 0);
        chk("final_stb_idle", int'(tm_stb), 1);
        chk("final_busy_idle", int'(host.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
